// File: rtl/host_bus_pkg.sv
// Shared encodings for the host-bus arbiter: rw codes, transfer sizes, FSM states.
package host_bus_pkg;

   localparam logic [1:0] RW_NOP   = 2'b00;
   localparam logic [1:0] RW_WRITE = 2'b01;
   localparam logic [1:0] RW_READ  = 2'b10;
   localparam logic [1:0] RW_BAD   = 2'b11;

   localparam logic [2:0] SIZE_8  = 3'd0;
   localparam logic [2:0] SIZE_16 = 3'd1;
   localparam logic [2:0] SIZE_32 = 3'd2;
   localparam logic [2:0] SIZE_64 = 3'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_CLEAR = 2'd2
   } arb_state_e;

   function automatic logic rw_is_access(input logic [1:0] rw);
      return (rw == RW_WRITE) || (rw == RW_READ);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request vector to one-hot grant. Round-robin from ptr by default;
// HOST_BUS_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins, no pointer).
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
`ifndef HOST_BUS_ARB_FIXED_PRIO_EN
   input  logic [PTR_W-1:0]   ptr,
`endif
   output logic [NUM_REQ-1:0] grant
);

`ifdef HOST_BUS_ARB_FIXED_PRIO_EN
   logic hit;

   always_comb begin
      grant = '0;
      hit   = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req[i] && !hit) begin
            grant[i] = 1'b1;
            hit      = 1'b1;
         end
      end
   end
`else
   logic [NUM_REQ-1:0] gnt_hi;
   logic [NUM_REQ-1:0] gnt_lo;
   logic               hit_hi;
   logic               hit_lo;

   // Wrap-around search: first requester at/above ptr, else the lowest one.
   always_comb begin
      gnt_hi = '0;
      gnt_lo = '0;
      hit_hi = 1'b0;
      hit_lo = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req[i] && !hit_hi && (i >= 32'(ptr))) begin
            gnt_hi[i] = 1'b1;
            hit_hi    = 1'b1;
         end
         if (req[i] && !hit_lo) begin
            gnt_lo[i] = 1'b1;
            hit_lo    = 1'b1;
         end
      end
      grant = hit_hi ? gnt_hi : gnt_lo;
   end
`endif

endmodule

// File: rtl/host_bus_arbiter.sv
// Arbitrates NUM_REQ requesters onto one host-bus master (IDLE -> ISSUE -> CLEAR).
// Build option: HOST_BUS_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module host_bus_arbiter
   import host_bus_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   output logic [NUM_REQ-1:0]        o_req_ready,
   input  logic [2*NUM_REQ-1:0]      i_req_rw,
   input  logic [ADDR_W*NUM_REQ-1:0] i_req_addr,
   input  logic [3*NUM_REQ-1:0]      i_req_wsize,
   input  logic [DATA_W*NUM_REQ-1:0] i_req_wdata,
   output logic [NUM_REQ-1:0]        o_resp_valid,
   output logic [DATA_W-1:0]         o_resp_rdata,
   output logic                      o_resp_error,
   output logic                      o_resp_invalid,
   output logic [ADDR_W-1:0]         o_m_addr,
   output logic [2:0]                o_m_wsize,
   output logic [DATA_W-1:0]         o_m_wdata,
   output logic [1:0]                o_m_rw,
   output logic                      o_m_clear_done,
   input  logic [DATA_W-1:0]         i_m_rdata,
   input  logic                      i_m_wait,
   input  logic                      i_m_done,
   input  logic                      i_m_invalid,
   input  logic                      i_m_error,
   output logic                      o_busy
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e          state;
   arb_state_e          state_nxt;
   logic [NUM_REQ-1:0]  grant;
   logic [NUM_REQ-1:0]  gnt_q;
   logic                accept;
   logic                complete;

   logic [1:0]          sel_rw;
   logic [ADDR_W-1:0]   sel_addr;
   logic [2:0]          sel_wsize;
   logic [DATA_W-1:0]   sel_wdata;

   logic [1:0]          rw_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [2:0]          wsize_q;
   logic [DATA_W-1:0]   wdata_q;

   logic [NUM_REQ-1:0]  resp_valid_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                error_q;
   logic                invalid_q;

   // Master wait is status only; sequencing relies on i_m_done alone.
   logic                unused_wait;
   assign unused_wait = i_m_wait;

`ifndef HOST_BUS_ARB_FIXED_PRIO_EN
   logic [PTR_W-1:0]    ptr_q;
   logic [PTR_W-1:0]    sel_idx;

   always_comb begin
      sel_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_idx = PTR_W'(i);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_q <= '0;
      end else if (accept) begin
         ptr_q <= (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
      end
   end
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .req   (i_req_valid),
`ifndef HOST_BUS_ARB_FIXED_PRIO_EN
      .ptr   (ptr_q),
`endif
      .grant (grant)
   );

   always_comb begin
      sel_rw    = RW_NOP;
      sel_addr  = '0;
      sel_wsize = '0;
      sel_wdata = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_rw    = i_req_rw[2*i +: 2];
            sel_addr  = i_req_addr[ADDR_W*i +: ADDR_W];
            sel_wsize = i_req_wsize[3*i +: 3];
            sel_wdata = i_req_wdata[DATA_W*i +: DATA_W];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Ready is gated by reset so no accept is advertised while reset is held.
   always_comb begin
      state_nxt      = state;
      o_req_ready    = '0;
      accept         = 1'b0;
      complete       = 1'b0;
      o_m_rw         = RW_NOP;
      o_m_clear_done = 1'b0;
      o_busy         = 1'b1;
      case (state)
         ST_IDLE: begin
            o_busy = 1'b0;
            if (i_rst_n && (|i_req_valid)) begin
               o_req_ready = grant;
               accept      = 1'b1;
               if (rw_is_access(sel_rw)) begin
                  state_nxt = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            o_m_rw = rw_q;
            if (i_m_done) begin
               complete  = 1'b1;
               state_nxt = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            o_m_clear_done = 1'b1;
            if (!i_m_done) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Payload is only reloaded when it will actually reach the master.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         gnt_q        <= '0;
         rw_q         <= RW_NOP;
         addr_q       <= '0;
         wsize_q      <= '0;
         wdata_q      <= '0;
         resp_valid_q <= '0;
         rdata_q      <= '0;
         error_q      <= 1'b0;
         invalid_q    <= 1'b0;
      end else begin
         resp_valid_q <= '0;
         if (accept) begin
            gnt_q <= grant;
            rw_q  <= sel_rw;
            if (rw_is_access(sel_rw)) begin
               addr_q  <= sel_addr;
               wsize_q <= sel_wsize;
               wdata_q <= sel_wdata;
            end else begin
               resp_valid_q <= grant;
               rdata_q      <= '0;
               error_q      <= 1'b0;
               invalid_q    <= 1'b1;
            end
         end
         if (complete) begin
            resp_valid_q <= gnt_q;
            rdata_q      <= i_m_rdata;
            error_q      <= i_m_error;
            invalid_q    <= i_m_invalid;
         end
      end
   end

   assign o_m_addr       = addr_q;
   assign o_m_wsize      = wsize_q;
   assign o_m_wdata      = wdata_q;
   assign o_resp_valid   = resp_valid_q;
   assign o_resp_rdata   = rdata_q;
   assign o_resp_error   = error_q;
   assign o_resp_invalid = invalid_q;

endmodule

// File: doc/host_bus_arbiter.md
HOST_BUS_ARBITER -- requirements
Module: host_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, host-bus address width.
REQ-003 SHALL have parameter DATA_W, default 64, host-bus data width.
REQ-004 SHALL have port i_clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports i_req_valid/o_req_ready  in/out  NUM_REQ  per-requester request/accept.
REQ-007 SHALL have ports i_req_rw (2/req), i_req_addr (ADDR_W/req), i_req_wsize (3/req), i_req_wdata (DATA_W/req)  in  packed, requester k at slice k.
REQ-008 SHALL have ports o_resp_valid  out  NUM_REQ  one-cycle completion pulse; o_resp_rdata  out  DATA_W; o_resp_error, o_resp_invalid  out  1 each.
REQ-009 SHALL have master-side ports o_m_addr (ADDR_W), o_m_wsize (3), o_m_wdata (DATA_W), o_m_rw (2), o_m_clear_done (1)  out; i_m_rdata (DATA_W), i_m_wait, i_m_done, i_m_invalid, i_m_error  in.
REQ-010 SHALL have port o_busy  out  1  high in any state except IDLE.

Function
REQ-011 SHALL run FSM IDLE -> ISSUE -> CLEAR -> IDLE; rw encodings 01 write, 10 read.
REQ-012 In IDLE with any i_req_valid set, SHALL pick grant g, assert o_req_ready[g] combinationally that cycle, and register g, rw, addr, wsize, wdata.
REQ-013 SHALL raise o_req_ready for at most one requester per cycle, only in IDLE.
REQ-014 Accepted rw of 00 or 11: SHALL not touch master; next cycle pulse o_resp_valid[g] with o_resp_invalid=1, error=0, rdata=0; return to IDLE.
REQ-015 Valid rw: SHALL enter ISSUE and drive o_m_rw/addr/wsize/wdata from registers starting the cycle after acceptance, held stable until i_m_done.
REQ-016 In ISSUE on i_m_done=1: SHALL capture i_m_rdata/i_m_error/i_m_invalid into o_resp_*, pulse o_resp_valid[g] next cycle, drive o_m_rw=00 and o_m_clear_done=1, enter CLEAR.
REQ-017 In CLEAR: SHALL hold o_m_clear_done=1 until i_m_done=0, then deassert it and enter IDLE.
REQ-018 o_resp_rdata/error/invalid SHALL hold until next completion.
REQ-019 Round-robin: pointer moves to g+1 (mod NUM_REQ) on each acceptance; search starts at pointer.
REQ-020 i_m_wait SHALL be ignored for sequencing (status only).
REQ-021 i_req_valid dropping while not granted SHALL drop the request with no response.
REQ-022 Minimum turnaround: accept, ISSUE, CLEAR, IDLE = 1 cycle + master latency + 1.

Reset
REQ-023 On i_rst_n=0 SHALL immediately force: state IDLE, pointer 0, o_m_rw=00, o_m_clear_done=0, o_req_ready=0, o_resp_valid=0, o_resp_*=0, o_m_addr/wsize/wdata=0, o_busy=0.
REQ-024 Reset mid-transaction SHALL abandon it without response; master reset is owned externally.

Configuration
REQ-025 With HOST_BUS_ARB_FIXED_PRIO_EN defined SHALL use fixed priority, lowest index wins, pointer removed; undefined SHALL use round-robin per REQ-019.

Structure
REQ-026 Package host_bus_pkg SHALL hold rw encodings (RW_NOP, RW_WRITE, RW_READ), FSM state enum, size encodings.
REQ-027 Grant selection SHALL be sub-module rr_arbiter (request vector, pointer -> one-hot grant), holding the macro switch.

Verification
REQ-028 Req0 write addr 0x2 wsize 0 wdata 0xAA, model done after 3 cycles -> o_m_rw=01 for 3 cycles, o_resp_valid[0] one pulse, o_m_clear_done one cycle, o_busy low after.
REQ-029 Req2 read addr 0x0, model returns 0x1122334455667788 -> o_resp_rdata equals it, o_resp_valid[2] only.
REQ-030 All 4 valid continuously, round-robin -> accept order 0,1,2,3,0; with macro -> always 0.
REQ-031 Req1 rw=11 -> no o_m_rw activity, o_resp_invalid=1 next cycle after accept.
REQ-032 Assert i_rst_n=0 during ISSUE with done held off -> o_m_rw=00 immediately, no o_resp_valid, IDLE after release.
REQ-033 Model holds i_m_done 3 cycles after clear -> CLEAR lasts 3 cycles, no new acceptance meanwhile.
